// File: rtl/reg_mem_pkg.sv
// Shared types and default widths for the register-memory responder.
// Holds no logic and has no latency; backpressure does not apply.
// Default widths give a 16 x 20-bit register file.
package reg_mem_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 20;
    localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } reg_mem_state_e;

    typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

endpackage

// File: rtl/reg_mem_array.sv
// Register storage with one synchronous write port and one registered read port.
// Latency: read data appears one cycle after rd_en and is held until the next read.
// No backpressure: both ports accept one access every cycle.
module reg_mem_array #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Storage has no reset; the responder clears it by walking every entry.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_dat_q;
    logic [DATA_WIDTH-1:0] rd_dat_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_en) begin
            rd_dat_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/reg_mem_responder.sv
// Register-bus responder: clears its array after reset, then serves one write or read per cycle.
// Latency: read data and RdData_Valid one cycle after RdEn; Err one cycle after a rejected command.
// No backpressure: commands during Busy, illegal or read-only writes are dropped and flagged by Err.
module reg_mem_responder
    import reg_mem_pkg::*;
#(
    parameter int                        ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int                        DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [2**ADDR_WIDTH-1:0] RO_MASK    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WrEn,
    input  logic                  RdEn,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  RdData_Valid,
    output logic                  Busy,
    output logic                  Err
);

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    reg_mem_state_e        state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  err_q, err_d;
    logic                  rd_vld_q, rd_vld_d;

    logic                  arr_wr_en;
    logic [ADDR_WIDTH-1:0] arr_wr_addr;
    logic [DATA_WIDTH-1:0] arr_wr_dat;
    logic                  arr_rd_en;

    logic                  wr_req;
    logic                  rd_req;
    logic                  ro_hit;

    assign wr_req = WrEn & ~RdEn;
    assign rd_req = RdEn & ~WrEn;
    assign ro_hit = RO_MASK[Address];

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        err_d       = 1'b0;
        rd_vld_d    = 1'b0;
        arr_wr_en   = 1'b0;
        arr_wr_addr = Address;
        arr_wr_dat  = WrData;
        arr_rd_en   = 1'b0;

        case (state_q)
            INIT: begin
                // Bus commands are refused while the clear walk owns the write port.
                arr_wr_en   = 1'b1;
                arr_wr_addr = init_cnt_q;
                arr_wr_dat  = '0;
                init_cnt_d  = init_cnt_q + ADDR_WIDTH'(1);
                err_d       = WrEn | RdEn;
                if (init_cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (wr_req) begin
                    if (ro_hit) begin
                        err_d = 1'b1;
                    end else begin
                        arr_wr_en = 1'b1;
                    end
                end
                if (rd_req) begin
                    arr_rd_en = 1'b1;
                    rd_vld_d  = 1'b1;
                end
                if (WrEn && RdEn) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            err_q      <= 1'b0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            err_q      <= err_d;
            rd_vld_q   <= rd_vld_d;
        end
    end

    reg_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst),
        .wr_en   (arr_wr_en),
        .wr_addr (arr_wr_addr),
        .wr_dat  (arr_wr_dat),
        .rd_en   (arr_rd_en),
        .rd_addr (Address),
        .rd_dat  (RdData)
    );

    assign RdData_Valid = rd_vld_q;
    assign Err          = err_q;
    assign Busy         = (state_q == INIT);

endmodule

// File: tb/tb_reg_mem_responder.sv
// Scoreboard bench for reg_mem_responder with address 15 configured read-only.
module tb_reg_mem_responder;

    typedef struct {
        bit          is_rd;
        logic [19:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        WrEn = 1'b0;
    logic        RdEn = 1'b0;
    logic [3:0]  Address = '0;
    logic [19:0] WrData = '0;
    logic [19:0] RdData;
    logic        RdData_Valid;
    logic        Busy;
    logic        Err;

    exp_t        sb[$];
    logic [19:0] mdl_mem [16];
    logic [15:0] ro_mask = 16'h8000;
    logic [19:0] hold = '0;
    int          init_left = 16;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    reg_mem_responder #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (20),
        .RO_MASK    (16'h8000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .Busy         (Busy),
        .Err          (Err)
    );

    // Remaining clear cycles as seen by the bench, independent of the DUT.
    always @(posedge clk or negedge rst) begin
        if (!rst) init_left <= 16;
        else if (init_left > 0) init_left <= init_left - 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_err();
        exp_t e;
        e.is_rd = 1'b0;
        e.data  = '0;
        sb.push_back(e);
    endtask

    task automatic cmd(input bit we, input bit re, input logic [3:0] a, input logic [19:0] d);
        exp_t e;
        @(posedge clk);
        #1;
        WrEn    = we;
        RdEn    = re;
        Address = a;
        WrData  = d;
        if (init_left > 0) begin
            if (we || re) push_err();
        end else if (we && re) begin
            push_err();
        end else if (we) begin
            if (ro_mask[a]) push_err();
            else mdl_mem[a] = d;
        end else if (re) begin
            e.is_rd = 1'b1;
            e.data  = mdl_mem[a];
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cmd(1'b0, 1'b0, 4'h0, 20'h0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        WrEn = 1'b0;
        RdEn = 1'b0;
        sb.delete();
        for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("rst_rddata", 32'(RdData), 32'h0);
            chk("rst_valid", 32'(RdData_Valid), 32'h0);
            chk("rst_err", 32'(Err), 32'h0);
            chk("rst_busy", 32'(Busy), 32'h1);
            hold = '0;
        end else begin
            chk("busy", 32'(Busy), 32'(init_left > 0));
            chk("vld_err_excl", 32'(RdData_Valid & Err), 32'h0);
            if (RdData_Valid || Err) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_resp: valid=%0b err=%0b with empty scoreboard at %0t",
                             RdData_Valid, Err, $time);
                end else begin
                    e = sb.pop_front();
                    chk("rd_valid", 32'(RdData_Valid), 32'(e.is_rd));
                    chk("err", 32'(Err), 32'(!e.is_rd));
                    if (e.is_rd) begin
                        chk("rd_data", 32'(RdData), 32'(e.data));
                        hold = e.data;
                    end else begin
                        chk("rd_hold", 32'(RdData), 32'(hold));
                    end
                end
            end else begin
                chk("rd_hold", 32'(RdData), 32'(hold));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Read while clearing, then wait out the remaining clear cycles.
        idle(2);
        cmd(1'b0, 1'b1, 4'd5, 20'h0);
        idle(14);

        cmd(1'b0, 1'b1, 4'd5, 20'h0);
        idle(1);

        cmd(1'b1, 1'b0, 4'd3, 20'hABCDE);
        cmd(1'b0, 1'b1, 4'd3, 20'h0);
        idle(1);

        cmd(1'b1, 1'b1, 4'd7, 20'h12345);
        idle(1);
        cmd(1'b0, 1'b1, 4'd7, 20'h0);
        idle(1);

        cmd(1'b1, 1'b0, 4'd15, 20'hFFFFF);
        cmd(1'b0, 1'b1, 4'd15, 20'h0);
        cmd(1'b1, 1'b0, 4'd14, 20'h2468A);
        cmd(1'b0, 1'b1, 4'd14, 20'h0);
        idle(1);

        for (int i = 0; i < 16; i++) cmd(1'b1, 1'b0, 4'(i), 20'(i * 20'h11111));
        for (int i = 0; i < 16; i++) cmd(1'b0, 1'b1, 4'(i), 20'h0);
        idle(1);

        // Reset in the middle of a read burst, then confirm the array came back cleared.
        for (int i = 0; i < 8; i++) cmd(1'b0, 1'b1, 4'(i), 20'h0);
        do_reset(2);
        idle(16);
        for (int i = 0; i < 16; i++) cmd(1'b0, 1'b1, 4'(i), 20'h0);
        idle(3);

        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
